// File: rtl/rdata_packetizer_if.sv
// AXI-Stream read-data bus leaving the packetizer.
// master drives the beat, slave returns tready.
interface rdata_packetizer_if #(
    parameter int unsigned DATA_WIDTH = 512
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/rdata_packetizer.sv
// DDR4 read-return packetizer.
// Tracks outstanding reads, buffers returned beats in a FWFT FIFO and tags TLAST per mode.
module rdata_packetizer #(
    parameter int unsigned DATA_WIDTH = 512,
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned MAX_PKT    = 16,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SLOTS-1:0]          ddr_read,
    input  logic [DATA_WIDTH-1:0]     rd_data,
    input  logic                      rd_data_en,
    input  logic [1:0]                mode,
    input  logic                      err_clr,
    rdata_packetizer_if.master        m_axis,
    output logic [CNT_WIDTH-1:0]      outstanding,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [2:0]                err_flags
);
    localparam int unsigned ISS_W = $clog2(SLOTS + 1);
    localparam int unsigned AW    = CNT_WIDTH + 1;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FC_W  = PTR_W + 1;
    localparam int unsigned PKT_W = $clog2(MAX_PKT + 1);

    logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
    logic [PKT_W-1:0]      pkt_q, pkt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FC_W-1:0]       count_q, count_d;
    logic [2:0]            err_q, err_d;
    logic [DATA_WIDTH:0]   mem_q [DEPTH];

    logic [ISS_W-1:0]      issued;
    logic [AW-1:0]         avail, out_next;
    logic                  under, sat, beat_last, full, valid, pop, push, drop;

    always_comb begin
        issued = '0;
        for (int i = 0; i < SLOTS; i++) begin
            issued = issued + ISS_W'(ddr_read[i]);
        end
    end

    always_comb begin
        avail    = {1'b0, outstanding_q} + AW'(issued);
        out_next = avail;
        under    = 1'b0;
        if (rd_data_en) begin
            if (avail == '0) begin
                under = 1'b1;
            end else begin
                out_next = avail - AW'(1);
            end
        end
        // The extra counter bit flags anything beyond the CNT_WIDTH range.
        sat           = out_next[CNT_WIDTH];
        outstanding_d = sat ? '1 : out_next[CNT_WIDTH-1:0];

        case (mode)
            2'd1:    beat_last = (out_next == '0);
            2'd2:    beat_last = (out_next == '0) || (pkt_q == PKT_W'(MAX_PKT - 1));
            default: beat_last = 1'b1;
        endcase
        // A beat nobody asked for cannot belong to a packet; close it off.
        if (under) beat_last = 1'b1;
    end

    always_comb begin
        valid    = (count_q != '0);
        full     = (count_q == FC_W'(DEPTH));
        pop      = valid && m_axis.tready;
        push     = rd_data_en && (!full || pop);
        drop     = rd_data_en && !push;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + FC_W'(push) - FC_W'(pop);

        pkt_d = pkt_q;
        if (push) begin
            if (beat_last) begin
                pkt_d = '0;
            end else if (pkt_q != PKT_W'(MAX_PKT)) begin
                // Saturating keeps long mode-1 packets from wrapping into a false MAX_PKT hit.
                pkt_d = pkt_q + PKT_W'(1);
            end
        end

        err_d = (err_clr ? 3'b000 : err_q) | {sat, under, drop};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding_q <= '0;
            pkt_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            err_q         <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            pkt_q         <= pkt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            err_q         <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {beat_last, rd_data};
        end
    end

    always_comb begin
        m_axis.tvalid = valid;
        m_axis.tkeep  = '1;
        m_axis.tdata  = valid ? mem_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
        m_axis.tlast  = valid ? mem_q[rd_ptr_q][DATA_WIDTH] : 1'b0;
    end

    assign outstanding = outstanding_q;
    assign fifo_count  = count_q;
    assign err_flags   = err_q;

endmodule

// File: tb/tb_rdata_packetizer.sv
// Self-checking bench for rdata_packetizer: directed scenarios plus a random phase,
// all checked every cycle against a queue-based reference model.
module tb_rdata_packetizer;
    localparam int unsigned DW   = 64;
    localparam int unsigned SL   = 4;
    localparam int unsigned CW   = 6;
    localparam int unsigned MP   = 16;
    localparam int unsigned DP   = 16;
    localparam int          CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [SL-1:0]        ddr_read = '0;
    logic [DW-1:0]        rd_data = '0;
    logic                 rd_data_en = 1'b0;
    logic [1:0]           mode = 2'd0;
    logic                 err_clr = 1'b0;
    logic [CW-1:0]        outstanding;
    logic [$clog2(DP):0]  fifo_count;
    logic [2:0]           err_flags;

    rdata_packetizer_if #(.DATA_WIDTH(DW)) axis_if ();

    rdata_packetizer #(
        .DATA_WIDTH(DW),
        .SLOTS     (SL),
        .CNT_WIDTH (CW),
        .MAX_PKT   (MP),
        .DEPTH     (DP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ddr_read   (ddr_read),
        .rd_data    (rd_data),
        .rd_data_en (rd_data_en),
        .mode       (mode),
        .err_clr    (err_clr),
        .m_axis     (axis_if),
        .outstanding(outstanding),
        .fifo_count (fifo_count),
        .err_flags  (err_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    int          n_assert = 0;
    int          n_fail   = 0;
    beat_t       m_q[$];
    int          m_out = 0;
    int          m_pkt = 0;
    logic [2:0]  m_err = 3'b000;
    bit          obs_last[$];
    logic [DW-1:0] first_data;
    int          n_last;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one clock edge worth of behaviour, from the rules directly.
    task automatic model_step();
        int issued, avail, nxt;
        bit under, sat, last, pop, drop;
        pop    = (m_q.size() > 0) && axis_if.tready;
        issued = $countones(ddr_read);
        avail  = m_out + issued;
        under  = 1'b0;
        nxt    = avail;
        if (rd_data_en) begin
            if (avail == 0) begin
                under = 1'b1;
                nxt   = 0;
            end else begin
                nxt = avail - 1;
            end
        end
        sat   = (nxt > CMAX);
        m_out = sat ? CMAX : nxt;
        case (mode)
            2'd1:    last = (nxt == 0);
            2'd2:    last = (nxt == 0) || (m_pkt + 1 == MP);
            default: last = 1'b1;
        endcase
        if (under) last = 1'b1;
        if (pop) m_q.delete(0);
        drop = 1'b0;
        if (rd_data_en) begin
            if (m_q.size() >= DP) begin
                drop = 1'b1;
            end else begin
                m_q.push_back('{last, rd_data});
                m_pkt = last ? 0 : m_pkt + 1;
            end
        end
        m_err = (err_clr ? 3'b000 : m_err) | {sat, under, drop};
    endtask

    task automatic check_outputs();
        chk("tvalid", axis_if.tvalid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            chk("tdata", axis_if.tdata, m_q[0].data);
            chk("tlast", axis_if.tlast, m_q[0].last);
        end
        chk("tkeep", axis_if.tkeep, {(DW/8){1'b1}});
        chk("outstanding", outstanding, m_out);
        chk("fifo_count", fifo_count, m_q.size());
        chk("err_flags", err_flags, m_err);
    endtask

    task automatic tick();
        if (axis_if.tvalid && axis_if.tready) obs_last.push_back(axis_if.tlast);
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic [SL-1:0] rd, input logic en, input logic clr);
        ddr_read   = rd;
        rd_data_en = en;
        rd_data    = en ? {$urandom, $urandom} : '0;
        err_clr    = clr;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        m_q.delete();
        m_out = 0;
        m_pkt = 0;
        m_err = 3'b000;
        chk("rst_tvalid", axis_if.tvalid, 1'b0);
        chk("rst_tlast", axis_if.tlast, 1'b0);
        chk("rst_tdata", axis_if.tdata, '0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_err_flags", err_flags, 3'b000);
        ddr_read   = '0;
        rd_data_en = 1'b0;
        err_clr    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [SL-1:0] rd;
        logic          en;
        axis_if.tready = 1'b0;
        do_reset();

        // Mode 1: four reads, four beats, TLAST only on the last one.
        mode = 2'd1;
        axis_if.tready = 1'b1;
        obs_last.delete();
        drive(4'hf, 1'b0, 1'b0);
        chk("m1_issue", outstanding, 4);
        for (int i = 0; i < 4; i++) begin
            drive('0, 1'b1, 1'b0);
            chk("m1_outstanding", outstanding, 3 - i);
        end
        repeat (3) drive('0, 1'b0, 1'b0);
        chk("m1_nbeats", obs_last.size(), 4);
        for (int i = 0; i < 4; i++) chk("m1_last", obs_last[i], i == 3);
        chk("m1_err", err_flags, 3'b000);

        // Mode 2: twenty reads, packet split at MAX_PKT and at drain.
        mode = 2'd2;
        obs_last.delete();
        repeat (5) drive(4'hf, 1'b0, 1'b0);
        chk("m2_issue", outstanding, 20);
        repeat (20) drive('0, 1'b1, 1'b0);
        repeat (3) drive('0, 1'b0, 1'b0);
        chk("m2_nbeats", obs_last.size(), 20);
        n_last = 0;
        foreach (obs_last[i]) n_last += int'(obs_last[i]);
        chk("m2_nlast", n_last, 2);
        chk("m2_last16", obs_last[15], 1'b1);
        chk("m2_last20", obs_last[19], 1'b1);

        // Mode 0 with backpressure: head beat must hold.
        mode = 2'd0;
        axis_if.tready = 1'b0;
        drive(4'b0111, 1'b0, 1'b0);
        drive('0, 1'b1, 1'b0);
        first_data = rd_data;
        repeat (2) drive('0, 1'b1, 1'b0);
        repeat (10) begin
            drive('0, 1'b0, 1'b0);
            chk("m0_hold", axis_if.tdata, first_data);
        end
        chk("m0_count", fifo_count, 3);
        obs_last.delete();
        axis_if.tready = 1'b1;
        repeat (4) drive('0, 1'b0, 1'b0);
        chk("m0_nbeats", obs_last.size(), 3);
        foreach (obs_last[i]) chk("m0_last", obs_last[i], 1'b1);

        // Overflow: 17 beats into a 16-deep buffer.
        axis_if.tready = 1'b0;
        repeat (4) drive(4'hf, 1'b0, 1'b0);
        drive(4'b0001, 1'b0, 1'b0);
        repeat (17) drive('0, 1'b1, 1'b0);
        chk("ovf_count", fifo_count, 16);
        chk("ovf_err", err_flags, 3'b001);
        chk("ovf_outstanding", outstanding, 0);
        drive('0, 1'b0, 1'b1);
        chk("ovf_clr", err_flags, 3'b000);
        // New errors beat a simultaneous clear.
        drive('0, 1'b1, 1'b1);
        chk("clr_vs_err", err_flags, 3'b011);
        drive('0, 1'b0, 1'b1);
        axis_if.tready = 1'b1;
        repeat (18) drive('0, 1'b0, 1'b0);
        chk("ovf_drained", fifo_count, 0);

        // Underflow, then same-cycle issue plus beat.
        obs_last.delete();
        drive('0, 1'b1, 1'b0);
        chk("unf_err", err_flags, 3'b010);
        chk("unf_outstanding", outstanding, 0);
        repeat (2) drive('0, 1'b0, 1'b0);
        chk("unf_nbeats", obs_last.size(), 1);
        chk("unf_last", obs_last[0], 1'b1);
        drive('0, 1'b0, 1'b1);
        drive(4'b0001, 1'b1, 1'b0);
        chk("same_cycle_err", err_flags, 3'b000);
        chk("same_cycle_out", outstanding, 0);
        repeat (2) drive('0, 1'b0, 1'b0);

        // Reset mid-packet, then a clean two-beat packet.
        mode = 2'd1;
        axis_if.tready = 1'b0;
        repeat (2) drive(4'hf, 1'b0, 1'b0);
        repeat (3) drive('0, 1'b1, 1'b0);
        do_reset();
        axis_if.tready = 1'b1;
        obs_last.delete();
        drive(4'b0011, 1'b0, 1'b0);
        repeat (2) drive('0, 1'b1, 1'b0);
        repeat (3) drive('0, 1'b0, 1'b0);
        chk("rpk_nbeats", obs_last.size(), 2);
        chk("rpk_last0", obs_last[0], 1'b0);
        chk("rpk_last1", obs_last[1], 1'b1);

        // Counter saturation.
        mode = 2'd0;
        repeat (17) drive(4'hf, 1'b0, 1'b0);
        chk("sat_out", outstanding, CMAX);
        chk("sat_err", err_flags, 3'b100);
        do_reset();

        // Random phase.
        for (int i = 0; i < 600; i++) begin
            if (i % 25 == 0) mode = 2'($urandom_range(0, 3));
            axis_if.tready = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 2) == 0 && m_out < 40) ? SL'($urandom) : '0;
            en = 1'($urandom_range(0, 1));
            if (m_q.size() >= DP && !axis_if.tready) en = 1'b0;
            drive(rd, en, $urandom_range(0, 31) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rdata_packetizer.md
Name: rdata_packetizer

Overview:
- Read-return packetizer between the DDR4 interface read port (rdData/rdDataEn) and the read-data AXI-Stream path. Sits in the DDR clock domain, ahead of the async read-data FIFO.
- Tracks outstanding reads issued by the decoder, up to SLOTS per cycle. Buffers returned beats in a local FIFO and generates TLAST according to a runtime-selectable mode.
- Flags protocol violations with sticky error bits.

Parameters:
- DATA_WIDTH, 512, read data beat width (multiple of 8)
- SLOTS, 4, read-command slots per clock (width of ddr_read)
- CNT_WIDTH, 16, width of the outstanding-read counter
- MAX_PKT, 16, beat limit per packet in mode 2 (>=1)
- DEPTH, 16, local buffer depth in beats (power of 2, >=2)

Ports:
- clk  in  1  DDR4 UI clock
- rst  in  1  asynchronous, active-high reset
- ddr_read  in  SLOTS  per-slot read-command issue strobes
- rd_data  in  DATA_WIDTH  returned read beat
- rd_data_en  in  1  rd_data valid; no backpressure possible
- mode  in  2  TLAST mode: 0 per-beat, 1 drain, 2 drain-or-MAX_PKT, 3 treated as 0
- err_clr  in  1  synchronous clear of err_flags
- m_axis_tdata  out  DATA_WIDTH  output beat
- m_axis_tkeep  out  DATA_WIDTH/8  always all-ones
- m_axis_tlast  out  1  packet end
- m_axis_tvalid  out  1  output beat valid
- m_axis_tready  in  1  downstream ready
- outstanding  out  CNT_WIDTH  current outstanding-read count
- fifo_count  out  clog2(DEPTH)+1  beats held in the buffer
- err_flags  out  3  sticky: [0] beat dropped (buffer full), [1] read-data underflow, [2] counter saturation

Behaviour:
- Reset (async assert, sync release): outstanding=0, pkt_beats=0, buffer empty, fifo_count=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, err_flags=0.
- issued = popcount(ddr_read), width clog2(SLOTS+1). avail = outstanding + issued, computed at CNT_WIDTH+1 bits.
- Beat handling when rd_data_en=1:
  - avail>=1: outstanding_next = avail-1.
  - avail==0: outstanding_next=0; err_flags[1] set; the beat is still buffered with tlast=1.
- No beat: outstanding_next = avail.
- Saturation: if outstanding_next > 2^CNT_WIDTH-1, outstanding holds at all-ones and err_flags[2] is set.
- TLAST is computed at write time from the mode sampled in the same cycle:
  - mode 0/3: tlast=1 on every beat.
  - mode 1: tlast = (outstanding_next==0).
  - mode 2: tlast = (outstanding_next==0) or (pkt_beats+1==MAX_PKT).
- pkt_beats counts buffered beats since the last tlast and resets to 0 when a tlast beat is written. A mode change mid-packet keeps pkt_beats; the new mode applies from the next beat.
- Buffer is first-word-fall-through. A beat written in cycle t gives m_axis_tvalid=1 in cycle t+1 at the earliest.
- Pop occurs on m_axis_tvalid && m_axis_tready; tdata/tlast stay stable while tvalid=1 and tready=0.
- Push while full:
  - Accepted only if a pop occurs in the same cycle.
  - Otherwise the beat is dropped and err_flags[0] set. The outstanding update still applies.
  - If the dropped beat carried tlast=1, the packet is left unterminated downstream. This is accepted; the error flag reports it.
- Simultaneous push and pop: fifo_count unchanged. Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH.
- err_flags:
  - Bits are OR-accumulated.
  - err_clr=1 clears all bits at the next edge.
  - If err_clr and a new error occur in the same cycle, the new error wins and its bit stays 1.
- Reset mid-packet discards buffered beats and counters. m_axis_tvalid drops immediately on rst assertion.
- Latency rd_data_en -> m_axis_tvalid: 1 cycle when the buffer is empty.

Test Plan:
- Mode 1: ddr_read=4'b1111 in one cycle, then 4 beats on consecutive cycles, tready=1 -> 4 output beats, tlast only on 4th; outstanding 4,3,2,1,0; err_flags=0.
- Mode 2, MAX_PKT=16: 20 reads issued over 5 cycles, 20 beats returned -> tlast on beats 16 and 20; pkt_beats back to 0.
- Mode 0: 3 reads issued, 3 beats returned with tready=0 for 10 cycles -> fifo_count=3, tdata of beat 1 held stable; after tready=1, 3 beats each with tlast=1.
- Overflow: tready=0, 17 reads issued, 17 beats returned (DEPTH=16) -> fifo_count=16, err_flags[0]=1, outstanding=0. err_clr pulse -> err_flags=0.
- Underflow: no reads issued, one rd_data_en beat -> beat output with tlast=1, err_flags[1]=1, outstanding stays 0. Same-cycle issue of 1 read plus a beat -> no error, outstanding=0.
- Reset mid-packet: mode 1, 8 issued, 3 beats buffered, rst pulse -> tvalid=0, outstanding=0, fifo_count=0. A subsequent 2-read/2-beat sequence ends with tlast on beat 2.
